seq_pattern_tx: RTL and testbench
=================================

Name: seq_pattern_tx

Overview:
Serial pattern transmitter, the source side of the team's 001/110 sequence detector. On a start request it emits a selected 3-bit pattern MSB-first, one bit per clock, repeated a programmable number of times, with idle-level gap bits between repetitions. It drives the detector's serial input i on the benches and in loopback.

Parameters:
W, 3, pattern width in bits
PAT_A, 3'b001, pattern sent when sel=0
PAT_B, 3'b110, pattern sent when sel=1
GAP, 1, idle-level bits between repetitions (0 = back-to-back)
IDLE_LVL, 1'b0, value of o when not sending a pattern bit
RW, 4, width of the repetition count

Ports:
ck  input  1  clock; all state updates on rising edge of ck (the detector samples on the falling edge, so i is stable at its sample point)
rs_n  input  1  reset, asynchronous, active-low
start  input  1  frame request, sampled only in IDLE
sel  input  1  pattern select: 0 = PAT_A, 1 = PAT_B
rep  input  RW  repetitions per frame, 1..2^RW-1
o  output  1  serial data, registered
busy  output  1  high in SEND and GAP
done  output  1  one-cycle pulse after the last pattern bit
st  output  2  current state, for debug and benches

Behaviour:
- States: IDLE=2'd0, SEND=2'd1, GAPS=2'd2, DONE=2'd3. Any other code goes to IDLE.
- Reset (rs_n=0, no clock needed): st=IDLE, o=IDLE_LVL, busy=0, done=0, all counters 0. Reset mid-frame aborts the frame and does not pulse done.
- Internal registers:
  - pat[W-1:0]
  - bit index bcnt (0..W-1)
  - repetitions left rcnt (RW bits)
  - gap counter gcnt (width clog2(GAP+1), minimum 1)
- IDLE, start=1 and rep!=0:
  - latch pat = sel ? PAT_B : PAT_A; rcnt=rep; bcnt=W-2.
  - o<=pat[W-1] on the same edge; go to SEND.
- IDLE, start=1 and rep==0: ignored; stay in IDLE; no busy, no done.
- sel and rep are captured only at acceptance. Later changes have no effect on the frame in flight.
- SEND:
  - Each edge: o<=pat[bcnt], then bcnt decrements.
  - The cycle after the last bit (index 0) is output, the repetition ends and rcnt decrements.
  - If that was the last repetition (rcnt was 1): o<=IDLE_LVL, go to DONE.
  - Else if GAP>0: o<=IDLE_LVL, gcnt=GAP-1, go to GAPS.
  - Else: o<=pat[W-1], bcnt=W-2, stay in SEND.
- GAPS:
  - o=IDLE_LVL.
  - At gcnt==0: o<=pat[W-1], bcnt=W-2, go to SEND.
  - Otherwise gcnt decrements.
- DONE: done=1 for exactly one cycle, busy=0, o=IDLE_LVL; go to IDLE. start is ignored in DONE.
- busy is registered and high exactly while st is SEND or GAPS. Frame length = rep*W + (rep-1)*GAP cycles.
- start while busy: ignored, with no queuing.
- start held high continuously: back-to-back frames separated by exactly 2 idle-level cycles (DONE, IDLE).
- Counters never wrap: rcnt reaches 0 only by leaving to DONE. rep=2^RW-1 is legal.

Decomposition:
- Shared package seq_pkg holds:
  - the state encodings IDLE/SEND/GAPS/DONE
  - the default patterns PAT_001=3'b001 and PAT_110=3'b110 (shared with the detector's state/output encoding)
- One natural sub-module, seq_shift: a W-bit pattern register with load and bit-index down-count, exposing the current bit and a last-bit flag. The FSM and repetition/gap counters stay in seq_pattern_tx.

Test Plan:
- Reset mid-frame: sel=1, rep=3, start, then rs_n=0 between clock edges -> st=0, o=0, busy=0, done=0 immediately; no done pulse after release.
- sel=0, rep=1, start one cycle -> o=0,0,1 on three consecutive cycles; busy=1 for 3 cycles; done=1 on the 4th cycle; st returns to 0.
- sel=1, rep=2, GAP=1 -> o=1,1,0,0,1,1,0; busy=1 for 7 cycles; done pulses exactly once.
- rep=0 with start=1 -> busy, done and o stay 0; st stays 0. Toggling sel/rep during a sel=0, rep=2 frame -> output still 0,0,1,0,0,0,1.
- start held high, sel=0, rep=1 -> o=0,0,1,0,0,0,0,1,...; second frame begins exactly 2 cycles after the first ends; start pulses during busy are ignored.
- Loopback into the 001/110 detector (detector on falling edge): sel=0, rep=1 -> detector y1=1 for one cycle, y2 stays 0. sel=1, rep=1 -> y2=1 for one cycle.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared encodings for the 001/110 pattern transmitter and its detector.
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAPS = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [2:0] PAT_001 = 3'b001;
  localparam logic [2:0] PAT_110 = 3'b110;

endpackage

// File: rtl/seq_pattern_tx_if.sv
// Request/serial-output bundle of the pattern transmitter; no flow control,
// the requester simply holds start and watches busy/done.
interface seq_pattern_tx_if #(
  parameter int RW = 4
);
  logic          start;
  logic          sel;
  logic [RW-1:0] rep;
  logic          o;
  logic          busy;
  logic          done;
  logic [1:0]    st;

  modport master (output start, sel, rep, input o, busy, done, st);
  modport slave  (input start, sel, rep, output o, busy, done, st);
endinterface

// File: rtl/seq_shift.sv
// Pattern register with MSB-first bit index; bit_o/last_o are valid the cycle
// after load/rewind/step, no backpressure (the FSM decides when to step).
module seq_shift #(
  parameter int W = 3
) (
  input  logic         ck,
  input  logic         rs_n,
  input  logic         load_i,
  input  logic         rewind_i,
  input  logic         step_i,
  input  logic [W-1:0] pat_i,
  output logic         bit_o,
  output logic         msb_o,
  output logic         last_o
);
  localparam int BW = (W > 2) ? $clog2(W) : 1;
  localparam logic [BW-1:0] IDX_START = BW'(W - 2);

  logic [W-1:0]  pat_q;
  logic [BW-1:0] bcnt_q;
  logic          last_q;

  // The MSB leaves on the load/rewind edge itself, so the index starts one below it.
  always_ff @(posedge ck or negedge rs_n) begin
    if (!rs_n) begin
      pat_q  <= '0;
      bcnt_q <= '0;
      last_q <= 1'b0;
    end else if (load_i) begin
      pat_q  <= pat_i;
      bcnt_q <= IDX_START;
      last_q <= 1'b0;
    end else if (rewind_i) begin
      bcnt_q <= IDX_START;
      last_q <= 1'b0;
    end else if (step_i) begin
      if (bcnt_q == '0) begin
        last_q <= 1'b1;
      end else begin
        bcnt_q <= bcnt_q - BW'(1);
      end
    end
  end

  assign bit_o  = pat_q[bcnt_q];
  assign msb_o  = pat_q[W-1];
  assign last_o = last_q;

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial 3-bit pattern transmitter: first bit on o the edge after an accepted start,
// frame = rep*W + (rep-1)*GAP cycles, then one DONE cycle; start is ignored unless IDLE.
module seq_pattern_tx
  import seq_pkg::*;
#(
  parameter int           W        = 3,
  parameter logic [W-1:0] PAT_A    = PAT_001,
  parameter logic [W-1:0] PAT_B    = PAT_110,
  parameter int           GAP      = 1,
  parameter logic         IDLE_LVL = 1'b0,
  parameter int           RW       = 4
) (
  input  logic             ck,
  input  logic             rs_n,
  seq_pattern_tx_if.slave  bus
);
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [GW-1:0] GAP_LD = (GAP > 0) ? GW'(GAP - 1) : '0;

  state_e        state_q;
  logic          o_q;
  logic          busy_q;
  logic          done_q;
  logic [RW-1:0] rcnt_q;
  logic [GW-1:0] gcnt_q;

  logic [W-1:0]  pat_d;
  logic          accept;
  logic          last_rep;
  logic          sh_rewind;
  logic          sh_step;
  logic          sh_bit;
  logic          sh_msb;
  logic          sh_last;

  assign pat_d    = bus.sel ? PAT_B : PAT_A;
  assign accept   = (state_q == IDLE) && bus.start && (bus.rep != '0);
  assign last_rep = (rcnt_q == RW'(1));
  assign sh_step  = (state_q == SEND) && !sh_last;
  // A new repetition restarts the index either straight away (no gap) or at the end of the gap.
  assign sh_rewind = ((state_q == SEND) && sh_last && !last_rep && (GAP == 0)) ||
                     ((state_q == GAPS) && (gcnt_q == '0));

  seq_shift #(.W(W)) u_shift (
    .ck       (ck),
    .rs_n     (rs_n),
    .load_i   (accept),
    .rewind_i (sh_rewind),
    .step_i   (sh_step),
    .pat_i    (pat_d),
    .bit_o    (sh_bit),
    .msb_o    (sh_msb),
    .last_o   (sh_last)
  );

  always_ff @(posedge ck or negedge rs_n) begin
    if (!rs_n) begin
      state_q <= IDLE;
      o_q     <= IDLE_LVL;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rcnt_q  <= '0;
      gcnt_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          o_q <= IDLE_LVL;
          if (accept) begin
            rcnt_q  <= bus.rep;
            o_q     <= pat_d[W-1];
            busy_q  <= 1'b1;
            state_q <= SEND;
          end
        end
        SEND: begin
          if (!sh_last) begin
            o_q <= sh_bit;
          end else begin
            rcnt_q <= rcnt_q - RW'(1);
            if (last_rep) begin
              o_q     <= IDLE_LVL;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else if (GAP > 0) begin
              o_q     <= IDLE_LVL;
              gcnt_q  <= GAP_LD;
              state_q <= GAPS;
            end else begin
              o_q <= sh_msb;
            end
          end
        end
        GAPS: begin
          if (gcnt_q == '0) begin
            o_q     <= sh_msb;
            state_q <= SEND;
          end else begin
            o_q    <= IDLE_LVL;
            gcnt_q <= gcnt_q - GW'(1);
          end
        end
        DONE: begin
          o_q     <= IDLE_LVL;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          o_q     <= IDLE_LVL;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.o    = o_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.st   = state_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Randomized bench for seq_pattern_tx against a frame-list reference model and a falling-edge 001/110 detector.
module tb_seq_pattern_tx;
  localparam int W   = 3;
  localparam int GAP = 1;
  localparam int RW  = 4;

  logic ck   = 1'b0;
  logic rs_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  seq_pattern_tx_if #(.RW(RW)) bus ();
  seq_pattern_tx #(.W(W), .GAP(GAP), .RW(RW)) dut (.ck(ck), .rs_n(rs_n), .bus(bus));

  always #5 ck = ~ck;

  // Loopback detector: 3-bit history sampled on the falling edge.
  logic [2:0] hist   = 3'b000;
  int         y1_cnt = 0;
  int         y2_cnt = 0;
  always @(negedge ck) begin
    hist <= {hist[1:0], bus.o};
    if ({hist[1:0], bus.o} == 3'b001) y1_cnt <= y1_cnt + 1;
    if ({hist[1:0], bus.o} == 3'b110) y2_cnt <= y2_cnt + 1;
  end

  // Reference frame: bit stream plus a flag marking gap cycles.
  bit exp_o[$];
  bit exp_gap[$];

  task automatic model(input bit s, input int r);
    logic [2:0] p;
    p = s ? 3'b110 : 3'b001;
    exp_o.delete();
    exp_gap.delete();
    for (int k = 0; k < r; k++) begin
      for (int b = W - 1; b >= 0; b--) begin
        exp_o.push_back(p[b]);
        exp_gap.push_back(1'b0);
      end
      if (k < r - 1)
        for (int g = 0; g < GAP; g++) begin
          exp_o.push_back(1'b0);
          exp_gap.push_back(1'b1);
        end
    end
  endtask

  // {o, busy, done, st} expected k cycles after the accepting edge.
  function automatic logic [4:0] exp_vec(input int k);
    int len;
    len = exp_o.size();
    if (k < len) return {exp_o[k], 1'b1, 1'b0, (exp_gap[k] ? 2'd2 : 2'd1)};
    if (k == len) return 5'b0_0_1_11;
    return 5'b0_0_0_00;
  endfunction

  task automatic test_reset();
    logic [4:0] obs;
    #1;
    obs = {bus.o, bus.busy, bus.done, bus.st};
    checks++;
    if (obs !== 5'b0) begin
      errors++;
      $display("FAIL reset_async: o/busy/done/st=%b required %b", obs, 5'b0);
    end
    bus.start = 1'b1;
    bus.rep   = 4'd2;
    repeat (3) @(posedge ck);
    #1;
    obs = {bus.o, bus.busy, bus.done, bus.st};
    checks++;
    if (obs !== 5'b0) begin
      errors++;
      $display("FAIL reset_held: o/busy/done/st=%b required %b", obs, 5'b0);
    end
    @(negedge ck);
    bus.start = 1'b0;
    rs_n = 1'b1;
    repeat (4) @(negedge ck);
  endtask

  task automatic test_frame(input string name, input bit s, input int r, input bit noise);
    logic [4:0] obs;
    logic [4:0] expv;
    int len;
    model(s, r);
    len = exp_o.size();
    @(negedge ck);
    bus.start = 1'b1;
    bus.sel   = s;
    bus.rep   = RW'(r);
    for (int k = 0; k <= len + 2; k++) begin
      @(posedge ck);
      #1;
      obs  = {bus.o, bus.busy, bus.done, bus.st};
      expv = exp_vec(k);
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL %s cycle %0d: o/busy/done/st=%b required %b", name, k, obs, expv);
      end
      // Requests and operand changes while busy or in DONE must leave the frame untouched.
      if (noise && k <= len) begin
        bus.start = 1'($urandom_range(0, 1));
        bus.sel   = 1'($urandom_range(0, 1));
        bus.rep   = RW'($urandom_range(0, 15));
      end else begin
        bus.start = 1'b0;
      end
    end
  endtask

  task automatic test_reject_zero();
    logic [4:0] obs;
    @(negedge ck);
    bus.start = 1'b1;
    bus.sel   = 1'($urandom_range(0, 1));
    bus.rep   = '0;
    for (int k = 0; k < 5; k++) begin
      @(posedge ck);
      #1;
      obs = {bus.o, bus.busy, bus.done, bus.st};
      checks++;
      if (obs !== 5'b0) begin
        errors++;
        $display("FAIL rep_zero cycle %0d: o/busy/done/st=%b required %b", k, obs, 5'b0);
      end
    end
    bus.start = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [4:0] obs;
    logic [4:0] expv;
    model(1'b0, 1);
    @(negedge ck);
    bus.start = 1'b1;
    bus.sel   = 1'b0;
    bus.rep   = 4'd1;
    for (int k = 0; k < 15; k++) begin
      @(posedge ck);
      #1;
      obs  = {bus.o, bus.busy, bus.done, bus.st};
      expv = exp_vec(k % (exp_o.size() + 2));
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL back_to_back cycle %0d: o/busy/done/st=%b required %b", k, obs, expv);
      end
    end
    bus.start = 1'b0;
    repeat (2) @(posedge ck);
  endtask

  task automatic test_reset_mid();
    logic [4:0] obs;
    int d0;
    @(negedge ck);
    bus.start = 1'b1;
    bus.sel   = 1'b1;
    bus.rep   = 4'd3;
    @(posedge ck);
    #1 bus.start = 1'b0;
    @(posedge ck);
    #1;
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_busy: busy=%b required 1", bus.busy);
    end
    #1 rs_n = 1'b0;
    #1;
    obs = {bus.o, bus.busy, bus.done, bus.st};
    checks++;
    if (obs !== 5'b0) begin
      errors++;
      $display("FAIL reset_mid_now: o/busy/done/st=%b required %b", obs, 5'b0);
    end
    @(negedge ck);
    rs_n = 1'b1;
    d0 = 0;
    repeat (12) begin
      @(posedge ck);
      #1;
      if ({bus.o, bus.busy, bus.done, bus.st} !== 5'b0) d0++;
    end
    checks++;
    if (d0 != 0) begin
      errors++;
      $display("FAIL reset_mid_after: %0d non-idle cycles after release, required 0", d0);
    end
  endtask

  task automatic test_loopback();
    int a1;
    int a2;
    repeat (4) @(negedge ck);
    a1 = y1_cnt;
    a2 = y2_cnt;
    test_frame("loop_a", 1'b0, 1, 1'b0);
    repeat (4) @(negedge ck);
    checks++;
    if (y1_cnt - a1 != 1 || y2_cnt - a2 != 0) begin
      errors++;
      $display("FAIL loop_a: y1 pulses=%0d y2 pulses=%0d required 1 and 0", y1_cnt - a1, y2_cnt - a2);
    end
    a2 = y2_cnt;
    test_frame("loop_b", 1'b1, 1, 1'b0);
    repeat (4) @(negedge ck);
    checks++;
    if (y2_cnt - a2 != 1) begin
      errors++;
      $display("FAIL loop_b: y2 pulses=%0d required 1", y2_cnt - a2);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 12; n++)
      test_frame("random", 1'($urandom_range(0, 1)), $urandom_range(1, 15), 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0;
    bus.sel   = 1'b0;
    bus.rep   = '0;
    test_reset();
    test_frame("single_a", 1'b0, 1, 1'b0);
    test_frame("gap_b", 1'b1, 2, 1'b0);
    test_reject_zero();
    test_frame("capture", 1'b0, 2, 1'b1);
    test_frame("rep_max", 1'b1, 15, 1'b0);
    test_back_to_back();
    test_reset_mid();
    test_loopback();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
